hex_disp_arbiter: RTL and testbench
===================================

HEX_DISP_ARBITER -- requirements
Module: hex_disp_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 25000000, minimum cycles a granted requester owns the display before another requester may write; legal range 1 to 2^32-1.
REQ-002 Port: clk_clk, in, 1, the single clock; all logic is on its rising edge.
REQ-003 Port: reset_reset, in, 1, synchronous, active-high reset.
REQ-004 Port: req_valid, in, 3, one valid bit per requester (bit i = requester i).
REQ-005 Port: req_ready, out, 3, one accept bit per requester; a write transfers when valid and ready are both 1 on a clock edge.
REQ-006 Port: req_sel, in, 6, target display channel for requester i at bits [2i+1:2i]; values 0..2 are legal and 3 is illegal.
REQ-007 Port: req_data, in, 24, byte for requester i at bits [8i+7:8i].
REQ-008 Ports: disp0_export, disp1_export, disp2_export, out, 8 each, registered bytes driving seven-segment converter channels 0..2.
REQ-009 Port: grant_id, out, 2, current owner index 0..2; value 3 means no owner.
REQ-010 Port: hold_busy, out, 1, high while the hold window is active.
REQ-011 Port: sel_err, out, 1, sticky flag set by any accepted write with req_sel = 3.

Function
REQ-012 The FSM SHALL have three states: IDLE, GRANT and HOLD.
REQ-013 IDLE: req_ready = 0 and grant_id = 3; if any req_valid is 1, the FSM moves to GRANT with the winner chosen round-robin, starting the search at (last_owner+1) mod 3.
REQ-014 GRANT (1 cycle): req_ready[winner] = 1 and grant_id = winner; the write is applied on that edge and the FSM moves to HOLD with the counter loaded to HOLD_CYCLES-1.
REQ-015 If the winner drops valid in GRANT, nothing is written, last_owner is still updated, and the FSM still enters HOLD.
REQ-016 HOLD: req_ready[owner] = 1 and other ready bits are 0; owner writes take effect each cycle and do not reload the counter; the FSM returns to IDLE when the counter reaches 0.
REQ-017 HOLD_CYCLES = 1: HOLD lasts exactly one cycle.
REQ-018 A write updates only disp<req_sel>_export, one cycle after acceptance (registered); the other channels keep their values.
REQ-019 A write with req_sel = 3 SHALL be accepted (ready asserted), change no display, and set sel_err, which holds until reset.
REQ-020 Minimum latency from valid rising in IDLE to the display update is 2 edges (IDLE->GRANT, GRANT write).
REQ-021 req_ready SHALL be a registered-state decode only, never a combinational function of req_valid.
REQ-022 Requesters not granted SHALL see ready = 0 and must hold valid, data and sel stable; no request is lost.
REQ-023 hold_busy = 1 exactly in HOLD.
REQ-024 The counter is 32 bits and does not wrap; it saturates at 0.

Reset
REQ-025 On reset_reset = 1 at a clock edge: state = IDLE, counter = 0, last_owner = 2 (so requester 0 wins first), all disp*_export = 8'h00, sel_err = 0, req_ready = 0, grant_id = 3, hold_busy = 0.
REQ-026 Reset asserted in GRANT or HOLD aborts the operation; the write on that edge is discarded and reset values apply.

Structure
REQ-027 A shared package holds the FSM state enum, NUM_REQ = 3, NUM_CH = 3, the GRANT_NONE = 2'd3 constant and the byte/select slice widths.
REQ-028 One sub-module, rr_arbiter3 (combinational round-robin pick from a 3-bit request vector and last_owner), is instantiated once; the rest is flat.

Verification
REQ-029 Reset release, then req_valid = 3'b001, sel0 = 1, data0 = 8'hA5 -> ready[0] pulses in GRANT; disp1_export = 8'hA5 two edges after valid; disp0 and disp2 stay 8'h00.
REQ-030 HOLD_CYCLES = 4, all three requesters valid continuously -> grants in order 0, 1, 2, 0; each grant separated by 1 IDLE + 1 GRANT + 4 HOLD cycles.
REQ-031 During HOLD of owner 1, requester 1 writes sel = 2, data = 8'h3C and requester 0 is valid -> disp2 = 8'h3C, ready[0] stays 0 until the FSM returns to IDLE, and the hold length is unchanged.
REQ-032 Accepted write with sel = 3 -> sel_err = 1 until reset; all displays unchanged.
REQ-033 Reset pulsed mid-HOLD while the owner writes 8'hFF -> write discarded, all outputs at reset values on the next cycle, and requester 0 wins the next arbitration.
REQ-034 HOLD_CYCLES = 1 with a single continuously valid requester -> a grant every 3 cycles; counter never underflows.

Source files
------------

// File: rtl/hex_disp_arbiter_pkg.sv
// Shared types and constants for the three-requester seven-segment display arbiter.
package hex_disp_arbiter_pkg;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned NUM_CH  = 3;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned CNT_W   = 32;

  localparam logic [ID_W-1:0]  GRANT_NONE = 2'd3;
  localparam logic [SEL_W-1:0] SEL_BAD    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_HOLD
  } state_e;

  typedef struct packed {
    logic              en;
    logic [SEL_W-1:0]  sel;
    logic [BYTE_W-1:0] data;
  } wr_req_t;

  // k-th candidate of a round-robin search that starts just after last.
  function automatic logic [ID_W-1:0] rr_cand(input logic [ID_W-1:0] last, input int unsigned k);
    int unsigned s;
    s = 32'(last) + 32'd1 + k;
    return ID_W'(s % NUM_REQ);
  endfunction

endpackage

// File: rtl/hex_disp_arbiter_rr.sv
// Combinational round-robin pick over three requesters, searching from last_owner+1.
module rr_arbiter3
  import hex_disp_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_owner,
  output logic               gnt_vld,
  output logic [ID_W-1:0]    gnt_id
);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = GRANT_NONE;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!gnt_vld && req[rr_cand(last_owner, k)]) begin
        gnt_vld = 1'b1;
        gnt_id  = rr_cand(last_owner, k);
      end
    end
  end

endmodule

// File: rtl/hex_disp_arbiter.sv
// Arbitrates three byte writers onto three display channels; a winner owns the
// display for HOLD_CYCLES cycles after its one-cycle grant.
module hex_disp_arbiter
  import hex_disp_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 32'd25000000
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  output logic [BYTE_W-1:0]         disp0_export,
  output logic [BYTE_W-1:0]         disp1_export,
  output logic [BYTE_W-1:0]         disp2_export,
  output logic [ID_W-1:0]           grant_id,
  output logic                      hold_busy,
  output logic                      sel_err
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_e                          state_q, state_d;
  logic [ID_W-1:0]                 owner_q, owner_d;
  logic [ID_W-1:0]                 last_q, last_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [NUM_CH-1:0][BYTE_W-1:0]   disp_q;
  logic                            sel_err_q;
  logic [NUM_REQ-1:0][SEL_W-1:0]   sel_arr;
  logic [NUM_REQ-1:0][BYTE_W-1:0]  data_arr;
  logic                            rr_vld;
  logic [ID_W-1:0]                 rr_id;
  wr_req_t                         wr;

  assign sel_arr  = req_sel;
  assign data_arr = req_data;

  rr_arbiter3 u_rr (
    .req        (req_valid),
    .last_owner (last_q),
    .gnt_vld    (rr_vld),
    .gnt_id     (rr_id)
  );

  // Ready depends only on registered state/owner, never on req_valid.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    grant_id  = GRANT_NONE;
    hold_busy = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rr_vld) begin
          state_d = ST_GRANT;
          owner_d = rr_id;
        end
      end
      ST_GRANT: begin
        req_ready[owner_q] = 1'b1;
        grant_id           = owner_q;
        last_d             = owner_q;
        cnt_d              = HOLD_LOAD;
        state_d            = ST_HOLD;
      end
      ST_HOLD: begin
        req_ready[owner_q] = 1'b1;
        grant_id           = owner_q;
        hold_busy          = 1'b1;
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    wr.en   = |(req_valid & req_ready);
    wr.sel  = sel_arr[owner_q];
    wr.data = data_arr[owner_q];
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      last_q    <= ID_W'(NUM_REQ - 1);
      cnt_q     <= '0;
      disp_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      // Select 3 matches no channel, so the write only raises the sticky flag.
      for (int c = 0; c < NUM_CH; c++)
        if (wr.en && wr.sel == SEL_W'(c)) disp_q[c] <= wr.data;
      if (wr.en && wr.sel == SEL_BAD) sel_err_q <= 1'b1;
    end
  end

  assign disp0_export = disp_q[0];
  assign disp1_export = disp_q[1];
  assign disp2_export = disp_q[2];
  assign sel_err      = sel_err_q;

endmodule

// File: tb/tb_hex_disp_arbiter.sv
// Directed vector bench: table of per-cycle expectations plus corner sequences.
module tb_hex_disp_arbiter;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [2:0]  valid_a, valid_b, ready_a, ready_b;
  logic [5:0]  sel_a, sel_b;
  logic [23:0] data_a, data_b;
  logic [7:0]  d0_a, d1_a, d2_a, d0_b, d1_b, d2_b;
  logic [1:0]  grant_a, grant_b;
  logic        busy_a, busy_b, err_a, err_b;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  hex_disp_arbiter #(.HOLD_CYCLES(4)) dut_a (
    .clk_clk(clk), .reset_reset(rst_a), .req_valid(valid_a), .req_ready(ready_a),
    .req_sel(sel_a), .req_data(data_a), .disp0_export(d0_a), .disp1_export(d1_a),
    .disp2_export(d2_a), .grant_id(grant_a), .hold_busy(busy_a), .sel_err(err_a)
  );

  hex_disp_arbiter #(.HOLD_CYCLES(1)) dut_b (
    .clk_clk(clk), .reset_reset(rst_b), .req_valid(valid_b), .req_ready(ready_b),
    .req_sel(sel_b), .req_data(data_b), .disp0_export(d0_b), .disp1_export(d1_b),
    .disp2_export(d2_b), .grant_id(grant_b), .hold_busy(busy_b), .sel_err(err_b)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  valid;
    logic [5:0]  sel;
    logic [23:0] data;
    bit          chk;
    logic [2:0]  ready;
    logic [1:0]  grant;
    logic        busy;
    logic [7:0]  d0, d1, d2;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [2:0] v, input logic [5:0] s,
                              input logic [23:0] d, input bit c, input logic [2:0] rdy,
                              input logic [1:0] g, input logic b, input logic [7:0] e0,
                              input logic [7:0] e1, input logic [7:0] e2, input logic er);
    vec_t x;
    x.rst = r; x.valid = v; x.sel = s; x.data = d; x.chk = c;
    x.ready = rdy; x.grant = g; x.busy = b; x.d0 = e0; x.d1 = e1; x.d2 = e2; x.err = er;
    return x;
  endfunction

  task automatic cmp(input string tag, input string fld, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s %s got %h want %h", tag, fld, act, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [2:0] rdy, input logic [1:0] g,
                         input logic b, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic er);
    n_vec++;
    cmp(tag, "ready", 8'(ready_a), 8'(rdy));
    cmp(tag, "grant", 8'(grant_a), 8'(g));
    cmp(tag, "busy",  8'(busy_a),  8'(b));
    cmp(tag, "disp0", d0_a, e0);
    cmp(tag, "disp1", d1_a, e1);
    cmp(tag, "disp2", d2_a, e2);
    cmp(tag, "sel_err", 8'(err_a), 8'(er));
  endtask

  task automatic drive_a(input logic r, input logic [2:0] v, input logic [5:0] s, input logic [23:0] d);
    @(negedge clk);
    rst_a = r; valid_a = v; sel_a = s; data_a = d;
    #1;
  endtask

  initial begin
    logic [5:0]  s29, s30, s31, s32, s33;
    logic [23:0] d29, d30, d31, d32, d33a, d33b;
    logic [7:0]  acc [3];
    logic [7:0]  eb1;
    logic [1:0]  pg;

    rst_a = 1'b1; valid_a = '0; sel_a = '0; data_a = '0;
    rst_b = 1'b1; valid_b = '0; sel_b = '0; data_b = '0;

    // Basic write: requester 0 to channel 1.
    s29 = 6'b00_01_01; d29 = 24'h0000A5;
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 3'b000, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 1, 3'b000, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b001, s29, d29, 1, 3'b000, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b001, s29, d29, 1, 3'b001, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 3'b000, s29, d29, 1, 3'b001, 0, 1, 8'h00, 8'hA5, 8'h00, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 1, 3'b000, 3, 0, 8'h00, 8'hA5, 8'h00, 0));

    // All three valid: grant order 0,1,2,0, each IDLE+GRANT+4 HOLD.
    s30 = 6'b10_01_00; d30 = 24'h332211;
    acc = '{8'h00, 8'h00, 8'h00};
    tbl.push_back(mk(0, 3'b111, s30, d30, 1, 3'b000, 3, 0, 0, 0, 0, 0));
    for (int o = 0; o < 3; o++) begin
      tbl.push_back(mk(0, 3'b111, s30, d30, 1, 3'(1 << o), 2'(o), 0, acc[0], acc[1], acc[2], 0));
      acc[o] = 8'h11 * 8'(o + 1);
      for (int h = 0; h < 4; h++)
        tbl.push_back(mk(0, 3'b111, s30, d30, 1, 3'(1 << o), 2'(o), 1, acc[0], acc[1], acc[2], 0));
      tbl.push_back(mk(0, 3'b111, s30, d30, 1, 3'b000, 3, 0, acc[0], acc[1], acc[2], 0));
    end
    tbl.push_back(mk(0, 3'b111, s30, d30, 1, 3'b001, 0, 0, 8'h11, 8'h22, 8'h33, 0));

    foreach (tbl[i]) begin
      drive_a(tbl[i].rst, tbl[i].valid, tbl[i].sel, tbl[i].data);
      if (tbl[i].chk)
        check_a($sformatf("vec%0d", i), tbl[i].ready, tbl[i].grant, tbl[i].busy,
                tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].err);
    end

    // Owner 1 writes channel 2 during HOLD while requester 0 waits.
    s31 = 6'b00_10_00; d31 = 24'h003C77;
    drive_a(1, 3'b000, 0, 0);
    drive_a(0, 3'b010, s31, d31); check_a("own1_idle",  3'b000, 3, 0, 8'h00, 8'h00, 8'h00, 0);
    drive_a(0, 3'b011, s31, d31); check_a("own1_grant", 3'b010, 1, 0, 8'h00, 8'h00, 8'h00, 0);
    for (int h = 0; h < 4; h++) begin
      drive_a(0, 3'b011, s31, d31);
      check_a($sformatf("own1_hold%0d", h), 3'b010, 1, 1, 8'h00, 8'h00, 8'h3C, 0);
    end
    drive_a(0, 3'b011, s31, d31); check_a("own1_ret",   3'b000, 3, 0, 8'h00, 8'h00, 8'h3C, 0);
    drive_a(0, 3'b001, s31, d31); check_a("own0_grant", 3'b001, 0, 0, 8'h00, 8'h00, 8'h3C, 0);
    drive_a(0, 3'b000, s31, d31); check_a("own0_hold",  3'b001, 0, 1, 8'h77, 8'h00, 8'h3C, 0);

    // Illegal select: accepted, displays untouched, sticky error.
    s32 = 6'b11_00_00; d32 = 24'h5A0000;
    drive_a(1, 3'b000, 0, 0);     check_a("pre_rst",  3'b001, 0, 1, 8'h77, 8'h00, 8'h3C, 0);
    drive_a(0, 3'b100, s32, d32); check_a("bad_idle",  3'b000, 3, 0, 0, 0, 0, 0);
    drive_a(0, 3'b100, s32, d32); check_a("bad_grant", 3'b100, 2, 0, 0, 0, 0, 0);
    drive_a(0, 3'b000, s32, d32); check_a("bad_hold",  3'b100, 2, 1, 0, 0, 0, 1);
    for (int h = 0; h < 3; h++) drive_a(0, 3'b000, s32, d32);
    drive_a(0, 3'b000, s32, d32); check_a("bad_sticky", 3'b000, 3, 0, 0, 0, 0, 1);
    drive_a(1, 3'b000, 0, 0);     check_a("bad_prerst", 3'b000, 3, 0, 0, 0, 0, 1);
    drive_a(0, 3'b000, 0, 0);     check_a("bad_clr",    3'b000, 3, 0, 0, 0, 0, 0);

    // Reset mid-HOLD discards the owner's write and restores priority to 0.
    s33 = 6'b00_01_00; d33a = 24'h004412; d33b = 24'h0044FF;
    drive_a(0, 3'b001, s33, d33a); check_a("mid_idle",  3'b000, 3, 0, 0, 0, 0, 0);
    drive_a(0, 3'b001, s33, d33a); check_a("mid_grant", 3'b001, 0, 0, 0, 0, 0, 0);
    drive_a(0, 3'b001, s33, d33a); check_a("mid_hold",  3'b001, 0, 1, 8'h12, 0, 0, 0);
    drive_a(1, 3'b001, s33, d33b); check_a("mid_rsted", 3'b001, 0, 1, 8'h12, 0, 0, 0);
    drive_a(0, 3'b011, s33, d33b); check_a("mid_after", 3'b000, 3, 0, 0, 0, 0, 0);
    drive_a(0, 3'b011, s33, d33b); check_a("mid_win0",  3'b001, 0, 0, 0, 0, 0, 0);

    // HOLD_CYCLES=1, single requester: IDLE, GRANT, HOLD repeating.
    @(negedge clk); rst_b = 1'b1; valid_b = '0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      rst_b = 1'b0; valid_b = 3'b010; sel_b = 6'b00_01_00; data_b = 24'h009C00;
      #1;
      pg  = (k % 3 == 0) ? 2'd3 : 2'd1;
      eb1 = (k >= 2) ? 8'h9C : 8'h00;
      n_vec++;
      cmp($sformatf("h1_c%0d", k), "grant", 8'(grant_b), 8'(pg));
      cmp($sformatf("h1_c%0d", k), "ready", 8'(ready_b), (k % 3 == 0) ? 8'h00 : 8'h02);
      cmp($sformatf("h1_c%0d", k), "busy",  8'(busy_b),  (k % 3 == 2) ? 8'h01 : 8'h00);
      cmp($sformatf("h1_c%0d", k), "disp1", d1_b, eb1);
      cmp($sformatf("h1_c%0d", k), "disp0", d0_b, 8'h00);
      cmp($sformatf("h1_c%0d", k), "disp2", d2_b, 8'h00);
      cmp($sformatf("h1_c%0d", k), "sel_err", 8'(err_b), 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
